// File: rtl/mips_register_file_if.sv
// mips_register_file_if: decode/writeback side bundle of the register file
interface mips_register_file_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  reg_write;
   logic [ADDR_WIDTH-1:0] read_register_1;
   logic [ADDR_WIDTH-1:0] read_register_2;
   logic [ADDR_WIDTH-1:0] write_register;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] read_data_1;
   logic [DATA_WIDTH-1:0] read_data_2;
   modport master (
      output reg_write, read_register_1, read_register_2, write_register, write_data,
      input  read_data_1, read_data_2
   );
   modport slave (
      input  reg_write, read_register_1, read_register_2, write_register, write_data,
      output read_data_1, read_data_2
   );
endinterface

// File: rtl/mips_register_file.sv
// mips_register_file: 32x32 GPR file, two async read ports, one sync write port, r0 hardwired to zero
module mips_register_file #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int WRITE_BYPASS = 0
) (
   input logic                 clock,
   input logic                 reset,
   mips_register_file_if.slave rf
);
   logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH];
   logic                  byp_1, byp_2;
   always_ff @(posedge clock)
      if (reset)
         for (int i = 0; i < 2**ADDR_WIDTH; i++) regs[i] <= '0;
      else if (rf.reg_write && rf.write_register != '0)
         regs[rf.write_register] <= rf.write_data;
   // address 0 is forced to zero on read, so a write to it is never bypassed
   always_comb begin
      byp_1 = (WRITE_BYPASS != 0) && rf.reg_write && rf.write_register == rf.read_register_1;
      byp_2 = (WRITE_BYPASS != 0) && rf.reg_write && rf.write_register == rf.read_register_2;
      rf.read_data_1 = rf.read_register_1 == '0 ? '0 : byp_1 ? rf.write_data : regs[rf.read_register_1];
      rf.read_data_2 = rf.read_register_2 == '0 ? '0 : byp_2 ? rf.write_data : regs[rf.read_register_2];
   end
endmodule

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file: scoreboarded directed test of both bypass variants driven in lockstep
module tb_mips_register_file;
   logic        clock = 1'b0;
   logic        reset;
   logic        reg_write;
   logic [4:0]  rr_1, rr_2, wr;
   logic [31:0] wd;
   int          errors = 0;
   int          checks = 0;
   typedef struct {
      string       tag;
      int          dut;
      int          port;
      logic [31:0] exp;
   } chk_t;
   chk_t q[$];

   always #5 clock = ~clock;

   mips_register_file_if b0 ();
   mips_register_file_if b1 ();
   assign b0.reg_write = reg_write;
   assign b0.read_register_1 = rr_1;
   assign b0.read_register_2 = rr_2;
   assign b0.write_register = wr;
   assign b0.write_data = wd;
   assign b1.reg_write = reg_write;
   assign b1.read_register_1 = rr_1;
   assign b1.read_register_2 = rr_2;
   assign b1.write_register = wr;
   assign b1.write_data = wd;

   mips_register_file #(.WRITE_BYPASS(0)) dut_0 (.clock(clock), .reset(reset), .rf(b0.slave));
   mips_register_file #(.WRITE_BYPASS(1)) dut_1 (.clock(clock), .reset(reset), .rf(b1.slave));

   // monitor: outputs are settled mid-cycle, so drain pending expectations on the falling edge
   always @(negedge clock) begin : monitor
      chk_t        c;
      logic [31:0] act;
      while (q.size() > 0) begin
         c = q.pop_front();
         act = c.dut == 0 ? (c.port == 1 ? b0.read_data_1 : b0.read_data_2)
                          : (c.port == 1 ? b1.read_data_1 : b1.read_data_2);
         checks++;
         if (act !== c.exp) begin
            errors++;
            $display("FAIL %s dut%0d port%0d: got %h expected %h", c.tag, c.dut, c.port, act, c.exp);
         end
      end
   end

   task automatic expect1(input string tag, input int dut, input int port, input logic [31:0] exp);
      chk_t c;
      c.tag = tag;
      c.dut = dut;
      c.port = port;
      c.exp = exp;
      q.push_back(c);
   endtask

   task automatic expect_all(input string tag, input logic [31:0] e1, input logic [31:0] e2);
      for (int d = 0; d < 2; d++) begin
         expect1(tag, d, 1, e1);
         expect1(tag, d, 2, e2);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] w, input logic [31:0] d,
                        input logic [4:0] a1, input logic [4:0] a2);
      reg_write = we;
      wr = w;
      wd = d;
      rr_1 = a1;
      rr_2 = a2;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      step();
      reset = 1'b0;
      for (int a = 0; a < 32; a++) begin
         drive(1'b0, 5'd3, 32'hFFFF_FFFF, 5'(a), 5'(31 - a));
         expect_all("reset_sweep", 32'd0, 32'd0);
         step();
      end
      drive(1'b1, 5'd0, 32'd1, 5'd0, 5'd0);
      expect_all("r0_write_pre", 32'd0, 32'd0);
      step();
      drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      expect_all("r0_write_post", 32'd0, 32'd0);
      step();
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 5'(i), 32'(3 * i + 1), 5'((i + 31) % 32), 5'(i));
         expect1("seq_rd1", 0, 1, i <= 1 ? 32'd0 : 32'(3 * (i - 1) + 1));
         expect1("seq_rd1", 1, 1, i <= 1 ? 32'd0 : 32'(3 * (i - 1) + 1));
         expect1("seq_rd2", 0, 2, 32'd0);
         expect1("seq_rd2_byp", 1, 2, i == 0 ? 32'd0 : 32'(3 * i + 1));
         step();
      end
      drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd17);
      expect_all("seq_final", 32'd94, 32'd52);
      step();
      drive(1'b1, 5'd7, 32'hDEAD_BEEF, 5'd6, 5'd8);
      step();
      drive(1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd7);
      expect_all("wdis_pre", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      step();
      drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd6);
      expect_all("wdis_post", 32'hDEAD_BEEF, 32'd19);
      step();
      reset = 1'b1;
      drive(1'b1, 5'd5, 32'hA5A5_A5A5, 5'd5, 5'd7);
      expect1("rst_prio_pre", 0, 1, 32'd16);
      step();
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd7);
      expect_all("rst_prio_post", 32'd0, 32'd0);
      step();
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 5'(i), 32'(100 + i), 5'd0, 5'd0);
         step();
      end
      drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd1);
      expect_all("mid_written", 32'd110, 32'd101);
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(11 - i));
         expect_all("mid_reset", 32'd0, 32'd0);
         step();
      end
      drive(1'b1, 5'd9, 32'h33, 5'd0, 5'd0);
      step();
      drive(1'b1, 5'd9, 32'h55, 5'd9, 5'd9);
      expect1("dual_old", 0, 1, 32'h33);
      expect1("dual_old", 0, 2, 32'h33);
      expect1("dual_byp", 1, 1, 32'h55);
      expect1("dual_byp", 1, 2, 32'h55);
      step();
      drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
      expect_all("dual_post", 32'h55, 32'h55);
      step();
      @(negedge clock);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
